trigger_scheduler: RTL and testbench

- Network-level controller for NUM_ACTORS per-actor trigger FSMs.
- Starts all triggers on a network ap_start.
- Computes the registered global predicates all_sleep, all_sync and all_sync_wait that the triggers consume.
- Latches per-actor completion, raises a single network ap_done when every trigger has finished, and counts sync rounds per invocation.

---
 rtl/trigger_scheduler_pkg.sv | 11 +
 rtl/trigger_sync_reducer.sv | 48 ++++
 rtl/trigger_scheduler.sv | 122 ++++++++++++
 tb/tb_trigger_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_scheduler_pkg.sv
// Shared types for the trigger network scheduler.
package trigger_scheduler_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_START = 2'd1,
    SCHED_RUN   = 2'd2,
    SCHED_DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/trigger_sync_reducer.sv
// Masked, registered AND-reductions of trigger status plus all_sync rising-edge detect.
module trigger_sync_reducer #(
  parameter int unsigned NUM_ACTORS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_ACTORS-1:0] i_sleep,
  input  logic [NUM_ACTORS-1:0] i_sync_exec,
  input  logic [NUM_ACTORS-1:0] i_sync_wait,
  input  logic [NUM_ACTORS-1:0] i_done_mask,
  input  logic                  i_enable,
  output logic                  o_all_sleep,
  output logic                  o_all_sync,
  output logic                  o_all_sync_wait,
  output logic                  o_sync_rise_c
);

  logic w_sleep;
  logic w_sync;
  logic w_sync_wait;
  logic r_all_sleep;
  logic r_all_sync;
  logic r_all_sync_wait;

  // Finished actors count as satisfied so late finishers see consistent predicates.
  assign w_sleep     = i_enable & (&(i_sleep | i_done_mask));
  assign w_sync      = i_enable & (&(i_sync_exec | i_sync_wait | i_done_mask));
  assign w_sync_wait = i_enable & (&(i_sync_wait | i_done_mask));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_all_sleep     <= 1'b0;
      r_all_sync      <= 1'b0;
      r_all_sync_wait <= 1'b0;
    end else begin
      r_all_sleep     <= w_sleep;
      r_all_sync      <= w_sync;
      r_all_sync_wait <= w_sync_wait;
    end
  end

  // High in the cycle whose edge takes the registered all_sync from 0 to 1.
  assign o_sync_rise_c   = w_sync & ~r_all_sync;
  assign o_all_sleep     = r_all_sleep;
  assign o_all_sync      = r_all_sync;
  assign o_all_sync_wait = r_all_sync_wait;

endmodule

// File: rtl/trigger_scheduler.sv
// Network-level controller: launches all triggers, aggregates their status, signals completion.
module trigger_scheduler
  import trigger_scheduler_pkg::*;
#(
  parameter int unsigned NUM_ACTORS = 4,
  parameter int unsigned ROUND_W    = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic [NUM_ACTORS-1:0] trig_start,
  input  logic [NUM_ACTORS-1:0] trig_done,
  input  logic [NUM_ACTORS-1:0] trig_sleep,
  input  logic [NUM_ACTORS-1:0] trig_sync_exec,
  input  logic [NUM_ACTORS-1:0] trig_sync_wait,
  output logic                  all_sleep,
  output logic                  all_sync,
  output logic                  all_sync_wait,
  output logic [ROUND_W-1:0]    sync_rounds,
  output logic                  busy
);

  localparam logic [NUM_ACTORS-1:0] ALL_ONES  = '1;
  localparam logic [ROUND_W-1:0]    ROUND_MAX = '1;

  sched_state_t          r_state;
  sched_state_t          w_state_nxt;
  logic [NUM_ACTORS-1:0] r_done_mask;
  logic [NUM_ACTORS-1:0] w_done_mask_nxt;
  logic [NUM_ACTORS-1:0] r_trig_start;
  logic                  r_ap_done;
  logic                  r_ap_idle;
  logic                  r_busy;
  logic [ROUND_W-1:0]    r_sync_rounds;
  logic                  w_agg_en;
  logic                  w_sync_rise;

  // Next-state and done-mask update.
  always_comb begin
    w_state_nxt     = r_state;
    w_done_mask_nxt = r_done_mask;
    case (r_state)
      SCHED_IDLE: begin
        if (ap_start) w_state_nxt = SCHED_START;
      end
      SCHED_START: begin
        w_done_mask_nxt = '0;
        w_state_nxt     = SCHED_RUN;
      end
      SCHED_RUN: begin
        w_done_mask_nxt = r_done_mask | trig_done;
        if ((r_done_mask | trig_done) == ALL_ONES) w_state_nxt = SCHED_DONE;
      end
      SCHED_DONE: begin
        w_state_nxt = SCHED_IDLE;
      end
      default: begin
        w_state_nxt = SCHED_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state      <= SCHED_IDLE;
      r_done_mask  <= '0;
      r_trig_start <= '0;
      r_ap_done    <= 1'b0;
      r_ap_idle    <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_done_mask  <= w_done_mask_nxt;
      r_trig_start <= (w_state_nxt == SCHED_START) ? ALL_ONES : '0;
      r_ap_done    <= (w_state_nxt == SCHED_DONE);
      r_ap_idle    <= (w_state_nxt == SCHED_IDLE);
      r_busy       <= (w_state_nxt == SCHED_START) || (w_state_nxt == SCHED_RUN);
    end
  end

  // Aggregates are only live while the network stays in RUN across the edge.
  assign w_agg_en = (r_state == SCHED_RUN) && (w_state_nxt == SCHED_RUN);

  trigger_sync_reducer #(
    .NUM_ACTORS (NUM_ACTORS)
  ) u_reducer (
    .i_clk           (ap_clk),
    .i_rst           (ap_rst),
    .i_sleep         (trig_sleep),
    .i_sync_exec     (trig_sync_exec),
    .i_sync_wait     (trig_sync_wait),
    .i_done_mask     (r_done_mask),
    .i_enable        (w_agg_en),
    .o_all_sleep     (all_sleep),
    .o_all_sync      (all_sync),
    .o_all_sync_wait (all_sync_wait),
    .o_sync_rise_c   (w_sync_rise)
  );

  // Saturating sync-round counter; held in IDLE for readout.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_sync_rounds <= '0;
    end else if (r_state == SCHED_START) begin
      r_sync_rounds <= '0;
    end else if (w_sync_rise && (r_sync_rounds != ROUND_MAX)) begin
      r_sync_rounds <= r_sync_rounds + ROUND_W'(1);
    end
  end

  assign trig_start  = r_trig_start;
  assign ap_done     = r_ap_done;
  assign ap_ready    = r_ap_done;
  assign ap_idle     = r_ap_idle;
  assign busy        = r_busy;
  assign sync_rounds = r_sync_rounds;

endmodule

// File: tb/tb_trigger_scheduler.sv
// Scoreboarded random/directed bench for trigger_scheduler (ROUND_W=16 and ROUND_W=2 instances).
module tb_trigger_scheduler;

  localparam int P_IDLE  = 0;
  localparam int P_START = 1;
  localparam int P_RUN   = 2;
  localparam int P_DONE  = 3;

  typedef struct packed {
    logic [3:0]  trig_start;
    logic        ap_done;
    logic        ap_ready;
    logic        ap_idle;
    logic        busy;
    logic        all_sleep;
    logic        all_sync;
    logic        all_sync_wait;
    logic [15:0] rounds;
    logic [1:0]  rounds2;
  } obs_t;

  logic       ap_clk = 1'b0;
  logic       ap_rst = 1'b1;
  logic       ap_start = 1'b0;
  logic [3:0] trig_done = '0;
  logic [3:0] trig_sleep = '0;
  logic [3:0] trig_sync_exec = '0;
  logic [3:0] trig_sync_wait = '0;

  logic        a_done, a_ready, a_idle, a_busy, a_sleep, a_sync, a_wait;
  logic [3:0]  a_tstart;
  logic [15:0] a_rounds;
  logic        b_done, b_ready, b_idle, b_busy, b_sleep, b_sync, b_wait;
  logic [3:0]  b_tstart;
  logic [1:0]  b_rounds;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  obs_t exp_q[$];

  // Reference model state (phase of the network, finished actors, rounds seen).
  int         m_ph = P_IDLE;
  logic [3:0] m_mask = '0;
  int         m_rounds = 0;
  logic       m_sleep = 0, m_sync = 0, m_wait = 0;

  always #5 ap_clk = ~ap_clk;

  trigger_scheduler #(.NUM_ACTORS(4), .ROUND_W(16)) dut_a (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(a_done), .ap_ready(a_ready), .ap_idle(a_idle),
    .trig_start(a_tstart), .trig_done(trig_done), .trig_sleep(trig_sleep),
    .trig_sync_exec(trig_sync_exec), .trig_sync_wait(trig_sync_wait),
    .all_sleep(a_sleep), .all_sync(a_sync), .all_sync_wait(a_wait),
    .sync_rounds(a_rounds), .busy(a_busy)
  );

  trigger_scheduler #(.NUM_ACTORS(4), .ROUND_W(2)) dut_b (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
    .ap_done(b_done), .ap_ready(b_ready), .ap_idle(b_idle),
    .trig_start(b_tstart), .trig_done(trig_done), .trig_sleep(trig_sleep),
    .trig_sync_exec(trig_sync_exec), .trig_sync_wait(trig_sync_wait),
    .all_sleep(b_sleep), .all_sync(b_sync), .all_sync_wait(b_wait),
    .sync_rounds(b_rounds), .busy(b_busy)
  );

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    int         nph;
    logic [3:0] nmask;
    logic       stay;
    obs_t       e;
    if (ap_rst) begin
      m_ph = P_IDLE; m_mask = '0; m_rounds = 0;
      m_sleep = 0; m_sync = 0; m_wait = 0;
    end else begin
      nph = m_ph;
      nmask = m_mask;
      case (m_ph)
        P_IDLE:  if (ap_start) nph = P_START;
        P_START: begin nph = P_RUN; nmask = '0; m_rounds = 0; end
        P_RUN:   begin nmask = m_mask | trig_done; if (nmask == 4'hF) nph = P_DONE; end
        default: nph = P_IDLE;
      endcase
      stay = (m_ph == P_RUN) && (nph == P_RUN);
      m_sleep = stay && ((trig_sleep | m_mask) == 4'hF);
      m_wait  = stay && ((trig_sync_wait | m_mask) == 4'hF);
      if (stay && ((trig_sync_exec | trig_sync_wait | m_mask) == 4'hF)) begin
        if (!m_sync) m_rounds++;
        m_sync = 1;
      end else begin
        m_sync = 0;
      end
      m_ph = nph;
      m_mask = nmask;
    end
    e.trig_start    = (m_ph == P_START) ? 4'hF : 4'h0;
    e.ap_done       = (m_ph == P_DONE);
    e.ap_ready      = (m_ph == P_DONE);
    e.ap_idle       = (m_ph == P_IDLE);
    e.busy          = (m_ph == P_START) || (m_ph == P_RUN);
    e.all_sleep     = m_sleep;
    e.all_sync      = m_sync;
    e.all_sync_wait = m_wait;
    e.rounds        = 16'((m_rounds > 65535) ? 65535 : m_rounds);
    e.rounds2       = 2'((m_rounds > 3) ? 3 : m_rounds);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic rst, input logic st, input logic [3:0] dn,
                     input logic [3:0] sl, input logic [3:0] se, input logic [3:0] sw);
    ap_rst = rst; ap_start = st; trig_done = dn;
    trig_sleep = sl; trig_sync_exec = se; trig_sync_wait = sw;
    @(posedge ap_clk);
    model_step();
    cycle++;
    #1;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  task automatic sync_window(input logic [3:0] se, input logic [3:0] sw);
    cyc(0, 0, 4'h0, 4'h0, se, sw);
    cyc(0, 0, 4'h0, 4'h0, se, sw);
    quiet(2);
  endtask

  // Monitor: every popped expectation is compared against both instances.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge ap_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {a_tstart, a_done, a_ready, a_idle, a_busy, a_sleep, a_sync, a_wait, a_rounds, e.rounds2};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs_w16 cycle %0d: got %h expected %h", cycle, a, e);
        end
        a = {b_tstart, b_done, b_ready, b_idle, b_busy, b_sleep, b_sync, b_wait, e.rounds, b_rounds};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs_w2 cycle %0d: got %h expected %h", cycle, a, e);
        end
      end
    end
  end

  initial begin
    logic [3:0] dn, sl, se, sw;
    cyc(1, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc(1, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    // Basic run: start at 0, done pulses at 5, 7, 9, 12.
    cyc(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int c = 1; c <= 16; c++) begin
      dn = (c == 5) ? 4'h1 : (c == 7) ? 4'h2 : (c == 9) ? 4'h4 : (c == 12) ? 4'h8 : 4'h0;
      cyc(0, (c == 3), dn, 4'h0, 4'h0, 4'h0);
    end
    // Sleep aggregation, three sync windows, simultaneous finish.
    cyc(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    quiet(2);
    cyc(0, 0, 4'h0, 4'h7, 4'h0, 4'h0);
    cyc(0, 0, 4'h0, 4'hF, 4'h0, 4'h0);
    cyc(0, 0, 4'h0, 4'hF, 4'h0, 4'h0);
    cyc(0, 0, 4'h0, 4'hB, 4'h0, 4'h0);
    quiet(2);
    sync_window(4'hF, 4'h0);
    sync_window(4'h0, 4'hF);
    sync_window(4'h5, 4'hA);
    cyc(0, 0, 4'hF, 4'h0, 4'h0, 4'h0);
    quiet(3);
    cyc(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    quiet(2);
    // Masked done: actor 0 finishes early, others sleep.
    cyc(0, 0, 4'h1, 4'h0, 4'h0, 4'h0);
    cyc(0, 0, 4'h0, 4'hE, 4'h0, 4'h0);
    cyc(0, 0, 4'h0, 4'hE, 4'h0, 4'h0);
    cyc(0, 0, 4'hE, 4'hE, 4'h0, 4'h0);
    quiet(2);
    // Reset mid-run with done_mask 0101, then a fresh run with saturation.
    cyc(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc(0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc(0, 0, 4'h1, 4'h0, 4'h0, 4'h0);
    sync_window(4'hF, 4'h0);
    cyc(0, 0, 4'h4, 4'h0, 4'h0, 4'h0);
    cyc(1, 1, 4'h0, 4'hF, 4'hF, 4'h0);
    quiet(2);
    cyc(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 5; k++) sync_window(4'hF, 4'h0);
    cyc(0, 1, 4'hF, 4'h0, 4'h0, 4'h0);
    quiet(2);
    // Randomized traffic with sync/sleep patterns biased towards all-ones.
    for (int n = 0; n < 3000; n++) begin
      dn = '0;
      for (int b = 0; b < 4; b++) dn[b] = ($urandom_range(0, 9) == 0);
      sl = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      case ($urandom_range(0, 3))
        0: begin se = 4'($urandom); sw = ~se; end
        1: begin se = 4'($urandom); sw = 4'hF; end
        default: begin se = 4'($urandom); sw = 4'($urandom); end
      endcase
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), dn, sl, se, sw);
    end
    repeat (3) @(negedge ap_clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
